// File: rtl/ps2_cmd_pkg.sv
// Shared types, scan-code constants and the key decode table for the PS/2 command decoder.
// Entries carry a command kind plus a digit that is only non-zero for DIGIT.
package ps2_cmd_pkg;

    typedef enum logic [2:0] {
        DIGIT  = 3'd0,
        UP     = 3'd1,
        DOWN   = 3'd2,
        LEFT   = 3'd3,
        RIGHT  = 3'd4,
        ENTER  = 3'd5,
        CLEAR  = 3'd6,
        ESCAPE = 3'd7
    } cmd_kind_t;

    typedef logic [2:0] dec_state_t;

    localparam dec_state_t ST_IDLE    = 3'd0;
    localparam dec_state_t ST_EXT     = 3'd1;
    localparam dec_state_t ST_BRK     = 3'd2;
    localparam dec_state_t ST_EXT_BRK = 3'd3;
    localparam dec_state_t ST_SKIP    = 3'd4;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_F0 = 8'hF0;

    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam logic [7:0] SC_X_UP    = 8'h75;
    localparam logic [7:0] SC_X_DOWN  = 8'h72;
    localparam logic [7:0] SC_X_LEFT  = 8'h6B;
    localparam logic [7:0] SC_X_RIGHT = 8'h74;
    localparam logic [7:0] SC_X_DEL   = 8'h71;

    // Pause is E1 followed by seven more bytes that carry no command.
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    localparam logic [7:0] SC_ROW_DIGIT [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                                8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] SC_PAD_DIGIT [9] = '{8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73,
                                                8'h74, 8'h6C, 8'h75, 8'h7D};

    typedef struct packed {
        cmd_kind_t  kind;
        logic [3:0] digit;
    } cmd_entry_t;

    typedef struct packed {
        logic       hit;
        cmd_entry_t ent;
    } dec_t;

    function automatic dec_t decode_key(input logic       ext,
                                        input logic [7:0] code,
                                        input logic       numpad_en);
        dec_t r;
        r = '0;
        if (ext) begin
            r.hit = 1'b1;
            case (code)
                SC_X_UP:    r.ent.kind = UP;
                SC_X_DOWN:  r.ent.kind = DOWN;
                SC_X_LEFT:  r.ent.kind = LEFT;
                SC_X_RIGHT: r.ent.kind = RIGHT;
                SC_ENTER:   r.ent.kind = ENTER;
                SC_X_DEL:   r.ent.kind = CLEAR;
                default:    r.hit = 1'b0;
            endcase
        end else begin
            r.hit = 1'b1;
            case (code)
                SC_ENTER: r.ent.kind = ENTER;
                SC_BKSP:  r.ent.kind = CLEAR;
                SC_ESC:   r.ent.kind = ESCAPE;
                default:  r.hit = 1'b0;
            endcase
            for (int i = 0; i < 9; i++) begin
                if (code == SC_ROW_DIGIT[i] || (numpad_en && code == SC_PAD_DIGIT[i])) begin
                    r.hit       = 1'b1;
                    r.ent.kind  = DIGIT;
                    r.ent.digit = 4'(i + 1);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with occupancy count; head is read straight from storage.
// Latency: a push at the end of cycle N is visible at the head in N+1 when the FIFO was empty.
// Backpressure: push while full is discarded unless a pop happens in the same cycle; pop while empty is ignored.
module cmd_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic               do_push, do_pop;

    always_comb begin
        do_pop   = pop_rdy && (count_q != '0);
        do_push  = push_vld && ((count_q != FULL_CNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_cmd_decoder.sv
// Decodes PS/2 scan-code sequences into Sudoku commands and queues them in a FIFO.
// Latency: the completing byte is written at the end of its rx_ready cycle; head visible next cycle.
// Backpressure: cmd_valid/cmd_ready pop; a full FIFO drops the command and pulses err_overflow.
module ps2_cmd_decoder
    import ps2_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1_250_000,
    parameter int NUMPAD_EN      = 1,
    parameter int ALLOW_REPEAT   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_ready,
    output cmd_kind_t                     cmd_kind,
    output logic [3:0]                    cmd_digit,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_timeout,
    output logic                          err_overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    dec_state_t     state_q, state_d;
    logic [2:0]     skip_q, skip_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [8:0]     held_q, held_d;
    logic           held_vld_q, held_vld_d;
    logic           err_timeout_q, err_timeout_d;
    logic           err_overflow_q, err_overflow_d;

    logic           key_ext, is_make, is_brk;
    logic [8:0]     rx_key;
    dec_t           key_dec;
    logic           push_vld;
    cmd_entry_t     push_dat;
    cmd_entry_t     head_dat;
    logic           fifo_full, fifo_empty;

    always_comb begin
        state_d        = state_q;
        skip_d         = skip_q;
        held_d         = held_q;
        held_vld_d     = held_vld_q;
        err_timeout_d  = 1'b0;
        err_overflow_d = 1'b0;
        push_vld       = 1'b0;
        push_dat       = '0;
        key_ext        = 1'b0;
        is_make        = 1'b0;
        is_brk         = 1'b0;
        timer_d        = (state_q == ST_IDLE) ? '0 : timer_q + 1'b1;

        if (rx_ready) begin
            timer_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SC_E0) begin
                        state_d = ST_EXT;
                    end else if (rx_data == SC_F0) begin
                        state_d = ST_BRK;
                    end else if (rx_data == SC_E1) begin
                        state_d = ST_SKIP;
                        skip_d  = PAUSE_TAIL;
                    end else begin
                        is_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_data == SC_F0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        key_ext = 1'b1;
                        is_make = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    is_brk  = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    key_ext = 1'b1;
                    is_brk  = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q == 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && timer_q == TMO_LAST) begin
            state_d       = ST_IDLE;
            timer_d       = '0;
            skip_d        = '0;
            err_timeout_d = 1'b1;
        end

        rx_key  = {key_ext, rx_data};
        key_dec = decode_key(key_ext, rx_data, NUMPAD_EN != 0);

        // The held key follows every accepted make, even when the FIFO has to drop it.
        if (is_make && key_dec.hit &&
            !(ALLOW_REPEAT == 0 && held_vld_q && held_q == rx_key)) begin
            held_d         = rx_key;
            held_vld_d     = 1'b1;
            push_vld       = 1'b1;
            push_dat       = key_dec.ent;
            err_overflow_d = fifo_full && !cmd_ready;
        end
        if (is_brk && held_vld_q && held_q == rx_key) begin
            held_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            skip_q         <= '0;
            timer_q        <= '0;
            held_q         <= '0;
            held_vld_q     <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            skip_q         <= skip_d;
            timer_q        <= timer_d;
            held_q         <= held_d;
            held_vld_q     <= held_vld_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    cmd_fifo #(
        .WIDTH ($bits(cmd_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (cmd_ready),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign cmd_valid    = !fifo_empty;
    assign cmd_kind     = head_dat.kind;
    assign cmd_digit    = head_dat.digit;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Randomised and directed scan-code stimulus against a byte-list reference model with a FIFO scoreboard.
module tb_ps2_cmd_decoder;

    localparam int DEPTH     = 4;
    localparam int TMO       = 16;
    localparam int NUMPAD    = 1;
    localparam int ALLOW_REP = 0;

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_E1 = 8'hE1;
    localparam logic [7:0] B_F0 = 8'hF0;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [2:0] cmd_kind;
    logic [3:0] cmd_digit;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] fifo_count;
    logic       err_timeout;
    logic       err_overflow;

    ps2_cmd_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .NUMPAD_EN      (NUMPAD),
        .ALLOW_REPEAT   (ALLOW_REP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .cmd_kind     (cmd_kind),
        .cmd_digit    (cmd_digit),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .fifo_count   (fifo_count),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending bytes of the current sequence, expected FIFO contents
    // (kind*16+digit), and the cycle numbers at which error pulses are due.
    int cyc = 0;
    int occ = 0;
    int idle_cnt = 0;
    int held = 0;
    bit held_v = 1'b0;
    int pend[$];
    int exp_q[$];
    int exp_ov[$];
    int exp_to[$];
    int dec_map [int];

    int rdy_mode = 0;
    int ready_pct = 50;

    logic [7:0] row_codes [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pad_codes [9] = '{8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    logic [7:0] pool [22] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                              8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D,
                              8'h5A, 8'h66, 8'h76, 8'h71};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic build_map();
        for (int i = 0; i < 9; i++) begin
            dec_map[int'(row_codes[i])] = i + 1;
            if (NUMPAD != 0) dec_map[int'(pad_codes[i])] = i + 1;
        end
        dec_map['h5A] = 5 * 16;
        dec_map['h66] = 6 * 16;
        dec_map['h76] = 7 * 16;
        dec_map[256 + 'h75] = 1 * 16;
        dec_map[256 + 'h72] = 2 * 16;
        dec_map[256 + 'h6B] = 3 * 16;
        dec_map[256 + 'h74] = 4 * 16;
        dec_map[256 + 'h5A] = 5 * 16;
        dec_map[256 + 'h71] = 6 * 16;
    endtask

    // Accumulate bytes until a complete sequence (optional E0, optional F0, code; or E1 + 7 bytes).
    task automatic model_byte(input int b, input bit pop_now, output bit pushed);
        int key;
        bit ext;
        bit brk;
        pushed = 1'b0;
        pend.push_back(b);
        if (pend[0] == int'(B_E1)) begin
            if (pend.size() == 8) pend.delete();
        end else if (pend.size() == 1 && (b == int'(B_E0) || b == int'(B_F0))) begin
            pushed = 1'b0;
        end else if (pend.size() == 2 && pend[0] == int'(B_E0) && b == int'(B_F0)) begin
            pushed = 1'b0;
        end else begin
            ext = (pend[0] == int'(B_E0));
            brk = (pend.size() == 3) || (pend.size() == 2 && pend[0] == int'(B_F0));
            key = (ext ? 256 : 0) + b;
            pend.delete();
            if (brk) begin
                if (held_v && held == key) held_v = 1'b0;
            end else if (dec_map.exists(key)) begin
                if (!(ALLOW_REP == 0 && held_v && held == key)) begin
                    held   = key;
                    held_v = 1'b1;
                    if (occ < DEPTH || pop_now) begin
                        exp_q.push_back(dec_map[key]);
                        pushed = 1'b1;
                    end else begin
                        exp_ov.push_back(cyc);
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        bit pop_now;
        bit pushed;
        cyc++;
        if (reset) begin
            pend.delete();
            exp_q.delete();
            exp_ov.delete();
            exp_to.delete();
            occ      = 0;
            idle_cnt = 0;
            held_v   = 1'b0;
        end else begin
            pop_now = cmd_ready && occ > 0;
            pushed  = 1'b0;
            if (rx_ready) begin
                idle_cnt = 0;
                model_byte(int'(rx_data), pop_now, pushed);
            end else if (pend.size() > 0) begin
                idle_cnt++;
                if (idle_cnt == TMO) begin
                    pend.delete();
                    exp_to.push_back(cyc);
                end
            end
            occ = occ + (pushed ? 1 : 0) - (pop_now ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        bit due;
        if (cyc > 0) begin
            chk("fifo_count", int'(fifo_count), occ);
            chk("cmd_valid", int'(cmd_valid), (occ > 0) ? 1 : 0);
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", int'({cmd_kind, cmd_digit}), -1);
                end else begin
                    chk("cmd_head", int'({cmd_kind, cmd_digit}), exp_q[0]);
                    if (cmd_ready) void'(exp_q.pop_front());
                end
            end
            due = (exp_ov.size() > 0 && exp_ov[0] == cyc);
            chk("err_overflow", int'(err_overflow), due ? 1 : 0);
            if (due) void'(exp_ov.pop_front());
            due = (exp_to.size() > 0 && exp_to[0] == cyc);
            chk("err_timeout", int'(err_timeout), due ? 1 : 0);
            if (due) void'(exp_to.pop_front());
        end
    end

    task automatic step(input logic v, input logic [7:0] d);
        rx_ready = v;
        rx_data  = d;
        if (rdy_mode == 2) cmd_ready = ($urandom_range(0, 99) < ready_pct);
        else cmd_ready = (rdy_mode == 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        step(1'b1, b);
        rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 12) return B_E0;
        if (r < 22) return B_F0;
        if (r < 24) return B_E1;
        if (r < 75) return pool[$urandom_range(0, 21)];
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 19);
        if (r < 10) return 0;
        if (r < 17) return $urandom_range(1, 3);
        if (r < 19) return $urandom_range(14, 17);
        return 20;
    endfunction

    initial begin
        int pulse_at;
        build_map();
        reset     = 1'b1;
        rx_ready  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
        idle(3);
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_kind", int'(cmd_kind), 0);
        chk("rst_digit", int'(cmd_digit), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_err_to", int'(err_timeout), 0);
        chk("rst_err_ov", int'(err_overflow), 0);
        reset    = 1'b0;
        rdy_mode = 1;

        send(8'h16, 1);
        chk("digit1_valid", int'(cmd_valid), 1);
        chk("digit1_head", int'({cmd_kind, cmd_digit}), 1);
        send(B_F0, 2); send(8'h16, 0);
        send(B_E0, 2); send(8'h75, 0); send(B_E0, 0); send(8'h75, 0);
        send(B_E0, 0); send(B_F0, 0); send(8'h75, 0); send(B_E0, 0); send(8'h75, 0);
        send(8'h72, 2); send(B_E0, 1); send(8'h72, 0);
        idle(4);

        rdy_mode = 0;
        send(8'h16, 0); send(8'h1E, 0); send(8'h26, 0); send(8'h25, 0); send(8'h2E, 0);
        chk("full_count", int'(fifo_count), 4);
        chk("ovf_pulse", int'(err_overflow), 1);
        rdy_mode = 1;
        send(8'h36, 0);
        chk("full_push_pop_count", int'(fifo_count), 4);
        idle(8);

        send(B_E0, 0);
        pulse_at = -1;
        for (int k = 1; k <= 20; k++) begin
            idle(1);
            if (err_timeout && pulse_at < 0) pulse_at = k;
        end
        chk("timeout_cycle", pulse_at, 16);
        send(8'h75, 0);
        chk("after_timeout_head", int'({cmd_kind, cmd_digit}), 8);
        send(B_E0, 3); send(8'h75, TMO - 1);
        chk("gap_boundary_head", int'({cmd_kind, cmd_digit}), 1 * 16);

        send(B_E1, 2); send(8'h14, 0); send(8'h77, 0); send(B_E1, 0);
        send(B_F0, 0); send(8'h14, 0); send(B_F0, 0); send(8'h77, 0);
        send(8'h5A, 1);
        chk("pause_then_enter", int'({cmd_kind, cmd_digit}), 5 * 16);

        send(B_E0, 2);
        do_reset();
        send(8'h6B, 0);
        chk("reset_then_6b_valid", int'(cmd_valid), 1);
        chk("reset_then_6b_head", int'({cmd_kind, cmd_digit}), 4);
        idle(4);

        rdy_mode = 2;
        for (int blk = 0; blk < 6; blk++) begin
            ready_pct = (blk % 2 == 0) ? 30 : 90;
            for (int n = 0; n < 250; n++) begin
                if ($urandom_range(0, 299) == 0) do_reset();
                send(pick_byte(), pick_gap());
            end
        end

        rdy_mode = 1;
        idle(TMO + 10);
        chk("leftover_cmds", exp_q.size(), 0);
        chk("leftover_ovf", exp_ov.size(), 0);
        chk("leftover_to", exp_to.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_decoder.md
Name: ps2_cmd_decoder

Overview:
- Parametrised successor to the single-byte keyboard command parser. Consumes PS/2 scan-code bytes from ps2_host and decodes make/break/extended/Pause sequences into Sudoku game commands.
- Adds optional numpad digits, a CLEAR and an ESCAPE command, typematic-repeat filtering and a sequence timeout.
- Commands are buffered in a FIFO with a valid/ready handshake toward the game FSM.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 1_250_000, idle cycles in a partial-sequence state before abort (≈25 ms at 50 MHz); ≥2.
- NUMPAD_EN, 1, 1 = non-extended keypad codes also produce digits.
- ALLOW_REPEAT, 0, 0 = drop typematic re-makes of the currently held key; 1 = pass them through.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  scan-code byte from ps2_host.
- rx_ready  in  1  single-cycle strobe; rx_data valid.
- cmd_kind  out  3  head entry kind (cmd_kind_t).
- cmd_digit  out  4  head entry digit 1–9; 0 unless kind=DIGIT.
- cmd_valid  out  1  FIFO non-empty.
- cmd_ready  in  1  consumer pop; pop when cmd_valid&&cmd_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- err_timeout  out  1  one-cycle pulse on sequence abort.
- err_overflow  out  1  one-cycle pulse when a decoded command is dropped because the FIFO is full.

Behaviour:
- One clock domain, synchronous active-high reset. Reset values: FSM=IDLE, FIFO empty, cmd_valid=0, cmd_kind=0, cmd_digit=0, fifo_count=0, both err pulses=0, held key cleared, timeout counter=0, Pause skip counter=0.
- Reset mid-sequence discards the partial sequence and the FIFO contents. No command is emitted.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (E1 Pause sequence).
- IDLE transitions:
  - E0→EXT
  - F0→BRK
  - E1→SKIP, with skip counter=7
  - other byte = make of a normal key; decode, stay in IDLE.
- EXT transitions: F0→EXT_BRK; other byte = extended make, go to IDLE.
- BRK and EXT_BRK: next byte = break code; go to IDLE.
- SKIP: each byte decrements the counter; return to IDLE when the counter reaches 0. No output is produced.
- Normal decode map:
  - 16,1E,26,25,2E,36,3D,3E,46 → DIGIT 1–9
  - 5A → ENTER
  - 66 → CLEAR
  - 76 → ESCAPE
  - if NUMPAD_EN: 69,72,7A,6B,73,74,6C,75,7D → DIGIT 1–9
  - all others ignored.
- Extended decode map: 75 UP, 72 DOWN, 6B LEFT, 74 RIGHT, 5A ENTER (keypad), 71 CLEAR (Delete); others ignored.
- Held key:
  - 9-bit {ext, code} register plus a valid flag.
  - A decodable make with ALLOW_REPEAT=0 matching the held key → dropped, no push.
  - Otherwise the make is pushed and the held key is updated.
  - A break matching the held key clears it. A non-matching break changes nothing.
  - Ignored (non-decodable) makes do not touch the held key.
- Timeout:
  - Counter runs while the FSM is not in IDLE and is cleared on every rx_ready.
  - When it reaches TIMEOUT_CYCLES−1, the FSM returns to IDLE and err_timeout pulses for one cycle. The held key is unchanged.
  - An rx_ready in the same cycle as the timeout wins: the byte is processed and there is no error.
- Latency: completing byte sampled with rx_ready in cycle N → entry written at the end of N. If the FIFO was empty, cmd_valid=1 and the head is visible in cycle N+1.
- FIFO ordering and head: first-in first-out. Head outputs are driven from FIFO storage and are stable while cmd_valid && !cmd_ready.
- Simultaneous push and pop: allowed at any occupancy including full; count unchanged.
- Push while full without a pop: command dropped, err_overflow pulses, the held key is still updated.
- Pop while empty: ignored.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Decomposition:
- Package ps2_cmd_pkg:
  - cmd_kind_t = {DIGIT=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, ENTER=5, CLEAR=6, ESCAPE=7}
  - dec_state_t
  - scan-code localparams (SC_E0, SC_E1, SC_F0, digit/arrow/keypad codes)
  - cmd_entry_t struct {kind, digit}.
- Sub-module cmd_fifo: parametrised synchronous FIFO (width = entry bits, depth = FIFO_DEPTH) with push/pop/full/empty/count. It is instantiated once. The decoder core holds the FSM, decode, held-key logic and timeout.

Test Plan:
- Bytes 16, F0 16 with cmd_ready=1 → one entry DIGIT/1, cmd_valid for one cycle; the break produces no entry.
- E0 75, E0 75, E0 F0 75, E0 75 with ALLOW_REPEAT=0 → exactly UP, UP. The second make is dropped as a repeat; the make after the release passes.
- 72 (NUMPAD_EN=1) then E0 72 → DIGIT/2 then DOWN. With NUMPAD_EN=0, only DOWN is produced.
- cmd_ready=0 with FIFO_DEPTH=4: send 1,2,3,4,5 (distinct keys) → fifo_count=4, err_overflow pulses once on 5. The pops yield digits 1,2,3,4 in order. Push and pop in the same cycle while full → count stays 4.
- Send E0 and then wait TIMEOUT_CYCLES (set to 16) → err_timeout pulses on cycle 16, FSM returns to IDLE. A subsequent 75 decodes as keypad DIGIT/8, not UP.
- Pause sequence E1 14 77 E1 F0 14 F0 77 followed by 5A → only ENTER is emitted. Asserting reset after E0 → no output, and the next 6B yields DIGIT/4.
